// File: rtl/wheel_fb_pkg.sv
// wheel_fb_pkg: shared wheel indices, direction encoding and quadrature helpers
package wheel_fb_pkg;

    localparam int WHEEL_NUM = 4;
    localparam int WHEEL_A   = 0;
    localparam int WHEEL_B   = 1;
    localparam int WHEEL_C   = 2;
    localparam int WHEEL_D   = 3;

    // Cycles after reset release spent loading previous-state registers only
    localparam logic [1:0] PRIME_CYCLES = 2'd3;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Position of a {b,a} pair along the forward Gray sequence 00->01->11->10
    function automatic logic [1:0] gray_pos(input logic [1:0] ba);
        return {ba[1], ba[1] ^ ba[0]};
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// quad_decoder: one wheel's synchronizer, optional glitch filter (ENC_GLITCH_FILTER_EN), 4x decode, saturating accumulator, pending error
module quad_decoder
    import wheel_fb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a,
    input  logic                    b,
    input  logic                    run,
    input  logic                    restart,
    output logic signed [CNT_W-1:0] acc,
    output logic                    err
);

    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] cur;
    logic [1:0] prev;
    logic [1:0] step;
    logic signed [1:0] delta;
    logic illegal;
    logic [CNT_W:0] sum;
    logic signed [CNT_W-1:0] sat;

    // Two-flop synchronizer on the {b,a} pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {b, a};
            s2 <= s1;
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    logic [1:0] s3;
    logic [1:0] filt;

    // A bit is accepted only once it has held the same value for two consecutive cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3   <= '0;
            filt <= '0;
        end else begin
            s3   <= s2;
            filt <= (s2 & ~(s2 ^ s3)) | (filt & (s2 ^ s3));
        end
    end

    assign cur = filt;
`else
    assign cur = s2;
`endif

    // Previous decoded state follows the input at all times so enabling never sees a stale step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= '0;
        else        prev <= cur;
    end

    // Gray distance gives direction; distance two means both bits moved at once
    always_comb begin
        step    = gray_pos(cur) - gray_pos(prev);
        illegal = step == 2'd2;
        delta   = step == 2'd1 ? 2'sd1 : step == 2'd3 ? -2'sd1 : 2'sd0;
        sum     = {acc[CNT_W-1], acc} + {{(CNT_W-1){delta[1]}}, delta};
        sat     = sum[CNT_W] == sum[CNT_W-1] ? sum[CNT_W-1:0]
                                             : {sum[CNT_W], {(CNT_W-1){~sum[CNT_W]}}};
    end

    // Accumulate within a window; the terminal cycle's step seeds the next window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            err <= 1'b0;
        end else if (!run) begin
            acc <= '0;
            err <= 1'b0;
        end else if (restart) begin
            acc <= CNT_W'(delta);
            err <= illegal;
        end else begin
            acc <= sat;
            err <= err | illegal;
        end
    end

endmodule

// File: rtl/wheel_encoder_feedback.sv
// wheel_encoder_feedback: four-wheel quadrature speed sampler; define ENC_GLITCH_FILTER_EN to add a 2-cycle input glitch filter
module wheel_encoder_feedback
    import wheel_fb_pkg::*;
#(
    parameter int WINDOW_CYCLES = 500000,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [WHEEL_NUM-1:0]    enc_a,
    input  logic [WHEEL_NUM-1:0]    enc_b,
    output logic signed [CNT_W-1:0] count_A,
    output logic signed [CNT_W-1:0] count_B,
    output logic signed [CNT_W-1:0] count_C,
    output logic signed [CNT_W-1:0] count_D,
    output logic [WHEEL_NUM-1:0]    dir,
    output logic [WHEEL_NUM-1:0]    err,
    output logic                    sample_valid
);

    localparam int WC_W = $clog2(WINDOW_CYCLES + 1);
    localparam logic [WC_W-1:0] LAST = WC_W'(WINDOW_CYCLES - 1);

    logic [1:0] prime;
    logic [WC_W-1:0] wcnt;
    logic run;
    logic terminal;
    logic signed [CNT_W-1:0] acc [WHEEL_NUM];
    logic signed [CNT_W-1:0] cnt [WHEEL_NUM];
    logic [WHEEL_NUM-1:0] perr;

    assign run      = enable && prime == PRIME_CYCLES;
    assign terminal = run && wcnt == LAST;

    // Priming counter: decoders only track input state until it saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     prime <= '0;
        else if (prime != PRIME_CYCLES) prime <= prime + 2'd1;
    end

    // Window counter runs only while measuring, so every window starts full-length
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= '0;
        else        wcnt <= (run && !terminal) ? wcnt + WC_W'(1) : '0;
    end

    for (genvar i = 0; i < WHEEL_NUM; i++) begin : g_wheel
        quad_decoder #(.CNT_W(CNT_W)) u_dec (
            .clk     (clk),
            .reset   (reset),
            .a       (enc_a[i]),
            .b       (enc_b[i]),
            .run     (run),
            .restart (terminal),
            .acc     (acc[i]),
            .err     (perr[i])
        );
    end

    // Publish the completed window and strobe sample_valid alongside it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '{default: '0};
            dir          <= '0;
            err          <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= terminal;
            if (terminal) begin
                for (int w = 0; w < WHEEL_NUM; w++) begin
                    cnt[w] <= acc[w];
                    dir[w] <= acc[w][CNT_W-1] ? DIR_REV : DIR_FWD;
                end
                err <= perr;
            end
        end
    end

    assign count_A = cnt[WHEEL_A];
    assign count_B = cnt[WHEEL_B];
    assign count_C = cnt[WHEEL_C];
    assign count_D = cnt[WHEEL_D];

endmodule

// File: doc/wheel_encoder_feedback.md
WHEEL_ENCODER_FEEDBACK -- requirements
Module: wheel_encoder_feedback

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 500000: speed sample window length in clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 16: width of each signed per-wheel count.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  measurement enable.
REQ-006 SHALL have port enc_a  in  4  quadrature channel A per wheel; bit0..3 = wheels A..D.
REQ-007 SHALL have port enc_b  in  4  quadrature channel B per wheel; same bit order.
REQ-008 SHALL have ports count_A, count_B, count_C, count_D  out  CNT_W  signed edges counted in the last completed window.
REQ-009 SHALL have port dir  out  4  per wheel: 0 = forward (count >= 0), 1 = reverse (count < 0).
REQ-010 SHALL have port err  out  4  per wheel: illegal transition seen in the last completed window.
REQ-011 SHALL have port sample_valid  out  1  one-cycle strobe when counts/dir/err update.

Function
REQ-012 SHALL pass every enc_a/enc_b bit through a 2-flop synchronizer before decoding.
REQ-013 SHALL decode 4x: Gray sequence {b,a} 00->01->11->10->00 adds +1; reverse sequence adds -1; no change adds 0.
REQ-014 SHALL treat both bits changing in one cycle as illegal: add 0, set that wheel's pending error flag.
REQ-015 SHALL saturate each accumulator at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)); no wrap-around.
REQ-016 SHALL count the window counter 0..WINDOW_CYCLES-1 while enable=1, wrapping to 0.
REQ-017 SHALL, in the terminal window cycle, latch accumulators into count_X, pending errors into err, sign bits into dir, and assert sample_valid for exactly that cycle's next clock edge output (one cycle high).
REQ-018 SHALL, on the terminal cycle, restart each accumulator at that cycle's delta (edge in terminal cycle belongs to the new window) and restart pending errors with that cycle's illegal flag.
REQ-019 SHALL, while enable=0, hold window counter, accumulators and pending errors at 0, hold all outputs, never assert sample_valid.
REQ-020 SHALL, on enable rising, start a full window of WINDOW_CYCLES cycles.
REQ-021 SHALL have input-edge-to-accumulator latency of 3 cycles (2 sync + 1 decode) without filter.

Reset
REQ-022 SHALL, on reset low, immediately clear synchronizers, previous-state registers, accumulators, window counter and set count_A..D=0, dir=0, err=0, sample_valid=0.
REQ-023 SHALL, for the first 3 cycles after reset release (priming), load previous-state registers from synchronized inputs without counting or flagging errors.
REQ-024 SHALL abort a window in progress on reset; the first sample_valid after release comes WINDOW_CYCLES cycles after priming ends (enable=1).

Configuration
REQ-025 SHALL, with ENC_GLITCH_FILTER_EN defined, accept a synchronized bit change only after it is stable 2 consecutive cycles (latency 5 cycles; 1-cycle pulses ignored).
REQ-026 SHALL, without ENC_GLITCH_FILTER_EN, decode synchronized bits directly per REQ-021.

Structure
REQ-027 SHALL place WHEEL_NUM=4, wheel index constants (WHEEL_A..WHEEL_D) and the DIR_FWD/DIR_REV encoding in shared package wheel_fb_pkg.
REQ-028 SHALL instantiate sub-module quad_decoder once per wheel (sync, optional filter, decode, saturating accumulator, pending error); window counter and output latch in the top.

Verification (WINDOW_CYCLES=100, CNT_W=16 unless stated)
REQ-029 SHALL cover: wheel A, 10 forward Gray cycles (40 edges, 2 cycles apart) in one window -> count_A=+40, dir[0]=0, sample_valid one cycle at window end.
REQ-030 SHALL cover: wheel C, 5 reverse cycles -> count_C=-20, dir[2]=1; other counts 0.
REQ-031 SHALL cover: wheel B, a and b toggled same cycle -> err[1]=1, count_B=0 that window; err[1]=0 next clean window.
REQ-032 SHALL cover: CNT_W=4, 12 forward edges in one window -> count_A=+7 (saturated); 12 reverse -> -8.
REQ-033 SHALL cover: reset low at window cycle 50 after 20 edges -> all outputs 0 immediately; next sample_valid 103 cycles after release, count_A reflects only post-release edges.
REQ-034 SHALL cover: 1-cycle pulse on enc_a[0] reaching the decoder in a window's terminal cycle -> without macro count_A=+1 then -1 next window; with ENC_GLITCH_FILTER_EN both windows 0.
